// File: rtl/gb_timer_pkg.sv
// Shared types and constants for the Game Boy DIV/TIMA/TMA/TAC timer.
package gb_timer_pkg;

  // CPU-visible register addresses.
  typedef enum logic [1:0] {
    ADDR_DIV  = 2'd0,
    ADDR_TIMA = 2'd1,
    ADDR_TMA  = 2'd2,
    ADDR_TAC  = 2'd3
  } reg_addr_e;

  // TIMA overflow handling state.
  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_OVF    = 1'b1
  } tim_state_e;

  // sys_cnt bit tapped for each TAC[1:0] clock select.
  localparam int TAP_IDX_00 = 9;
  localparam int TAP_IDX_01 = 3;
  localparam int TAP_IDX_10 = 5;
  localparam int TAP_IDX_11 = 7;

  // Unimplemented TAC bits read back as ones.
  localparam logic [4:0] TAC_RD_PAD = 5'b11111;

  // Ticks counted down after overflow before the reload tick.
  localparam logic [1:0] OVF_DELAY = 2'd3;

  // Selected tap bit of the system counter.
  function automatic logic tac_tap(input logic [15:0] cnt, input logic [1:0] sel);
    case (sel)
      2'b00:   return cnt[TAP_IDX_00];
      2'b01:   return cnt[TAP_IDX_01];
      2'b10:   return cnt[TAP_IDX_10];
      default: return cnt[TAP_IDX_11];
    endcase
  endfunction

endpackage

// File: rtl/gb_div_counter.sv
// 16-bit free-running system counter behind DIV; clear has priority over tick.
module gb_div_counter (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        tick_in,
  input  logic        clr_in,
  output logic [15:0] cnt_out
);

  logic [15:0] r_cnt;

  // Count one per T-cycle tick; a DIV write zeroes the counter instead.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt <= 16'h0000;
    end else if (clr_in) begin
      r_cnt <= 16'h0000;
    end else if (tick_in) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign cnt_out = r_cnt;

endmodule

// File: rtl/gb_timer.sv
// Game Boy timer: DIV/TIMA/TMA/TAC registers, falling-edge TIMA clocking,
// delayed TMA reload after overflow and a one-cycle interrupt request.
module gb_timer
  import gb_timer_pkg::*;
#(
  parameter int TICK_HZ = 4_194_304
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       tick_in,
  input  logic       wr_en_in,
  input  logic [1:0] addr_in,
  input  logic [7:0] wr_data_in,
  output logic [7:0] rd_data_out,
  output logic       irq_out
);

  // TICK_HZ is informational only; an empty guard block records that it must be positive.
  generate
    if (TICK_HZ <= 0) begin : g_bad_tick_rate
    end
  endgenerate

  logic [15:0] w_sys_cnt;
  logic        w_div_wr;
  logic        w_tima_wr;
  logic        w_tma_wr;
  logic        w_tac_wr;
  logic        w_inc;
  logic        w_inc_fall;
  logic [7:0]  w_tma_eff;

  logic [2:0]  r_tac;
  logic [7:0]  r_tima;
  logic [7:0]  r_tma;
  logic [1:0]  r_delay;
  logic        r_irq;
  logic        r_inc_prev;
  tim_state_e  r_state;

  logic [7:0]  w_tima_next;
  logic [1:0]  w_delay_next;
  logic        w_irq_next;
  tim_state_e  w_state_next;

  assign w_div_wr  = wr_en_in && (addr_in == ADDR_DIV);
  assign w_tima_wr = wr_en_in && (addr_in == ADDR_TIMA);
  assign w_tma_wr  = wr_en_in && (addr_in == ADDR_TMA);
  assign w_tac_wr  = wr_en_in && (addr_in == ADDR_TAC);

  gb_div_counter u_div (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .tick_in (tick_in),
    .clr_in  (w_div_wr),
    .cnt_out (w_sys_cnt)
  );

  // Increment source is evaluated from the current counter and TAC, so ticks,
  // DIV clears and TAC writes all produce falling edges the same way.
  assign w_inc      = r_tac[2] & tac_tap(w_sys_cnt, r_tac[1:0]);
  assign w_inc_fall = r_inc_prev & ~w_inc;

  // A TMA write landing on the reload cycle is forwarded into TIMA.
  assign w_tma_eff  = w_tma_wr ? wr_data_in : r_tma;

  // Plain registers: TAC, TMA and the edge-detect history (updated every clock).
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_tac      <= 3'b000;
      r_tma      <= 8'h00;
      r_inc_prev <= 1'b0;
    end else begin
      if (w_tac_wr) r_tac <= wr_data_in[2:0];
      if (w_tma_wr) r_tma <= wr_data_in;
      r_inc_prev <= w_inc;
    end
  end

  // TIMA/overflow state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_NORMAL;
      r_tima  <= 8'h00;
      r_delay <= 2'd0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tima  <= w_tima_next;
      r_delay <= w_delay_next;
      r_irq   <= w_irq_next;
    end
  end

  // Next-state logic: count TIMA in NORMAL; in OVF hold TIMA at 0 (increments
  // are ignored) and reload from TMA on the tick after the delay runs out.
  always_comb begin
    w_state_next = r_state;
    w_tima_next  = r_tima;
    w_delay_next = r_delay;
    w_irq_next   = 1'b0;
    case (r_state)
      ST_NORMAL: begin
        if (w_tima_wr) begin
          w_tima_next = wr_data_in;
        end else if (w_inc_fall) begin
          if (r_tima == 8'hFF) begin
            w_tima_next  = 8'h00;
            w_delay_next = OVF_DELAY;
            w_state_next = ST_OVF;
          end else begin
            w_tima_next = r_tima + 8'd1;
          end
        end
      end
      ST_OVF: begin
        if (w_tima_wr) begin
          w_tima_next  = wr_data_in;
          w_delay_next = 2'd0;
          w_state_next = ST_NORMAL;
        end else if (tick_in) begin
          if (r_delay != 2'd0) begin
            w_delay_next = r_delay - 2'd1;
          end else begin
            w_tima_next  = w_tma_eff;
            w_irq_next   = 1'b1;
            w_state_next = ST_NORMAL;
          end
        end
      end
      default: w_state_next = ST_NORMAL;
    endcase
  end

  // Zero-latency register read mux.
  always_comb begin
    rd_data_out = 8'h00;
    case (addr_in)
      ADDR_DIV:  rd_data_out = w_sys_cnt[15:8];
      ADDR_TIMA: rd_data_out = r_tima;
      ADDR_TMA:  rd_data_out = r_tma;
      default:   rd_data_out = {TAC_RD_PAD, r_tac};
    endcase
  end

  assign irq_out = r_irq;

endmodule

// File: doc/gb_timer.md
# gb_timer

Game Boy DIV/TIMA/TMA/TAC timer block. It sits directly downstream of the clock-enable tick generator. It consumes one tick per emulated T-cycle, advances a 16-bit system counter, and exposes the four timer registers to the CPU bus. On TIMA overflow it raises a one-clock timer interrupt request for the interrupt controller.

## Interface
- `TICK_HZ`, default 4_194_304: nominal tick rate. Documentation only; no logic depends on it.
- `clk_in`, input, 1: system clock. The only clock.
- `rst_n_in`, input, 1: reset, asynchronous, active-low.
- `tick_in`, input, 1: T-cycle enable. High for one `clk_in` cycle per emulated T-cycle.
- `wr_en_in`, input, 1: register write strobe. Sampled on `clk_in`; does not need to coincide with `tick_in`.
- `addr_in`, input, 2: register select. 0 = DIV, 1 = TIMA, 2 = TMA, 3 = TAC.
- `wr_data_in`, input, 8: write data.
- `rd_data_out`, output, 8: combinational read of the register selected by `addr_in`.
- `irq_out`, output, 1: timer interrupt request. One `clk_in`-cycle pulse.

## Operation
- System counter `sys_cnt[15:0]`:
  - +1 on every `tick_in`, wraps 0xFFFF to 0x0000.
  - DIV reads `sys_cnt[15:8]`.
  - Any DIV write clears `sys_cnt` to 0, whatever `wr_data_in` is. A DIV write wins over a simultaneous `tick_in`.
- TAC (3 bits):
  - bit 2 is enable.
  - bits 1:0 select the tap: 00 → `sys_cnt[9]`, 01 → `[3]`, 10 → `[5]`, 11 → `[7]`.
  - TAC reads back as `{5'b11111, tac}`.
- Increment signal: `inc = tac[2] & tap`.
  - A 1→0 transition of `inc` between consecutive clocks increments TIMA.
  - The transition can come from a tick, a DIV write, or a TAC write; all three count.
- State machine with states NORMAL and OVF:
  - NORMAL → OVF: TIMA increments from 0xFF. TIMA becomes 0x00 and the 2-bit delay counter is loaded with 3.
  - OVF, on each `tick_in` with delay ≠ 0: delay decrements.
  - OVF, on a `tick_in` with delay = 0: TIMA ← TMA, `irq_out` = 1 for that cycle, go to NORMAL. The reload therefore happens on the 4th tick after the overflow.
  - OVF, TIMA write: TIMA takes the written value, go to NORMAL. The reload is cancelled and no irq is raised.
- TMA: a plain register. A TMA write in the same cycle as the reload makes the reload use the new value.
- TIMA write in NORMAL:
  - The written value wins over a simultaneous increment.
  - An overflow is not flagged for that cycle.
- Reset values:
  - `sys_cnt`, TIMA, TMA = 0; TAC = 0; state = NORMAL; delay = 0; `irq_out` = 0.
  - `rd_data_out` therefore reads 0x00 at addresses 0–2 and 0xF8 at address 3.
- A reset asserted mid-OVF discards the pending reload and irq.

## Timing
- Register updates take effect on the `clk_in` edge that samples `tick_in` or `wr_en_in`. They are visible on `rd_data_out` in the following cycle.
- `rd_data_out` has zero latency from `addr_in`; there is no read strobe.
- `irq_out` is registered and is high for exactly one `clk_in` cycle per reload. It is never high on consecutive cycles.
- Edge detection uses a registered copy of `inc`, updated every clock, not only on ticks.
- The first TIMA increment after enabling depends only on the tap bit's falling edge, not on how long ago TAC was written.

## Structure
- Shared package `gb_timer_pkg` holds:
  - an enum for register addresses (DIV, TIMA, TMA, TAC);
  - an enum for state (NORMAL, OVF);
  - localparams for the TAC tap indices (9, 3, 5, 7) and `TAC_RD_PAD = 5'b11111`.
- One sub-module, `gb_div_counter`:
  - contains the 16-bit `sys_cnt` with tick enable and synchronous clear;
  - outputs the full counter vector.
- Everything else (tap mux, edge detect, TIMA/OVF FSM, register file, read mux) lives in `gb_timer`.

## Test plan
1. Reset, TAC = 0, 256 ticks → DIV reads 0x01, TIMA stays 0x00, `irq_out` never asserted.
2. TAC = 0x05, `sys_cnt` = 0, 16 ticks → TIMA = 0x01. After 64 ticks in total, TIMA = 0x04.
3. TMA = 0xAB, TIMA = 0xFF, TAC = 0x05, tick to overflow → TIMA reads 0x00 for the next 3 ticks. On the 4th tick TIMA = 0xAB and `irq_out` is high for exactly one clock.
4. Same setup as 3, TIMA ← 0x42 written 2 ticks after the overflow → TIMA = 0x42, state NORMAL, `irq_out` stays 0.
5. TAC = 0x05, `sys_cnt` = 0x0008 (tap bit = 1), DIV write → DIV = 0x00 and TIMA increments by exactly 1.
6. `rst_n_in` asserted during OVF, without a clock edge → all registers clear immediately, TAC reads 0xF8. After release, `irq_out` stays 0 with no reload.
